// File: rtl/stq_pkg.sv
// Shared constants, types and helpers for the store-queue data bank.
// Default geometry lives here so the bank and its entries agree on it.
package stq_pkg;

    localparam int unsigned STQ_WIDTH     = 32;
    localparam int unsigned STQ_DEPTH     = 64;
    localparam int unsigned STQ_NWR       = 2;
    localparam int unsigned STQ_NRD       = 8;
    localparam int unsigned STQ_MAX_DEPTH = 128;

    // Outcome of decoding one check port's select vector.
    typedef enum logic [1:0] {
        CHK_NONE  = 2'd0,
        CHK_HIT   = 2'd1,
        CHK_MULTI = 2'd2
    } chk_kind_e;

    function automatic int unsigned stq_nbytes(input int unsigned width);
        return width / 32'd8;
    endfunction

    localparam int unsigned STQ_NBYTES = stq_nbytes(STQ_WIDTH);

    // Clearing the lowest set bit leaves something behind only if two or more were set.
    function automatic logic stq_multi_hot(input logic [STQ_MAX_DEPTH-1:0] vec);
        return |(vec & (vec - {{(STQ_MAX_DEPTH-1){1'b0}}, 1'b1}));
    endfunction

endpackage

// File: rtl/stq_data_entry.sv
// One store-queue data entry: byte-merged data register fed by every write port,
// plus its valid bit. Higher-numbered write ports win on a shared byte.
module stq_data_entry
    import stq_pkg::*;
#(
    parameter int unsigned WIDTH = STQ_WIDTH,
    parameter int unsigned NWR   = STQ_NWR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NWR-1:0]                  wr_sel,
    input  logic [NWR*WIDTH-1:0]            wr_data,
    input  logic [NWR*stq_nbytes(WIDTH)-1:0] wr_be,
    input  logic                            clr,
    output logic [WIDTH-1:0]                data,
    output logic                            vld
);

    localparam int unsigned NB = stq_nbytes(WIDTH);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] next_data_s;
    logic             any_wr_s;
    logic             vld_r;

    // Byte merge: ascending port order lets the highest-numbered port land last.
    always_comb begin
        next_data_s = data_r;
        for (int p = 0; p < NWR; p++) begin
            for (int b = 0; b < NB; b++) begin
                next_data_s[b*8 +: 8] = (wr_sel[p] && wr_be[p*NB + b])
                                      ? wr_data[p*WIDTH + b*8 +: 8]
                                      : next_data_s[b*8 +: 8];
            end
        end
    end

    // Any selecting port counts as a write, even with every byte enable low.
    always_comb begin
        any_wr_s = |wr_sel;
    end

    // Data storage is deliberately not reset; reset only blocks updates.
    always_ff @(posedge clk) begin
        if (!rst && any_wr_s) begin
            data_r <= next_data_s;
        end
    end

    // Valid bit: reset beats write, write beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= 1'b0;
        end else if (any_wr_s) begin
            vld_r <= 1'b1;
        end else if (clr) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= vld_r;
        end
    end

    assign data = data_r;
    assign vld  = vld_r;

endmodule

// File: rtl/stq_data_bank.sv
// Store-queue data bank: DEPTH byte-writable entries with NWR write ports and
// NRD registered one-hot check ports for store-to-load forwarding.
module stq_data_bank
    import stq_pkg::*;
#(
    parameter int unsigned WIDTH = STQ_WIDTH,
    parameter int unsigned DEPTH = STQ_DEPTH,
    parameter int unsigned NWR   = STQ_NWR,
    parameter int unsigned NRD   = STQ_NRD
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NWR*DEPTH-1:0]             wrt_en,
    input  logic [NWR*WIDTH-1:0]             wrt_data,
    input  logic [NWR*stq_nbytes(WIDTH)-1:0] wrt_be,
    input  logic [DEPTH-1:0]                 clr_en,
    input  logic [NRD*DEPTH-1:0]             chk_en,
    output logic [NRD*WIDTH-1:0]             chk_data,
    output logic [NRD-1:0]                   chk_vld,
    output logic [NRD-1:0]                   chk_err,
    output logic [DEPTH-1:0]                 ent_vld
);

    logic [NWR-1:0]   wr_sel_s   [DEPTH];
    logic [WIDTH-1:0] ent_data_s [DEPTH];
    logic [DEPTH-1:0] ent_vld_s;

    genvar e, p, r;

    generate
        for (e = 0; e < DEPTH; e++) begin : g_entry
            for (p = 0; p < NWR; p++) begin : g_sel
                assign wr_sel_s[e][p] = wrt_en[p*DEPTH + e];
            end

            stq_data_entry #(
                .WIDTH (WIDTH),
                .NWR   (NWR)
            ) u_entry (
                .clk     (clk),
                .rst     (rst),
                .wr_sel  (wr_sel_s[e]),
                .wr_data (wrt_data),
                .wr_be   (wrt_be),
                .clr     (clr_en[e]),
                .data    (ent_data_s[e]),
                .vld     (ent_vld_s[e])
            );
        end
    endgenerate

    assign ent_vld = ent_vld_s;

    generate
        for (r = 0; r < NRD; r++) begin : g_chk
            logic [DEPTH-1:0]         sel_s;
            logic [STQ_MAX_DEPTH-1:0] sel_ext_s;
            logic [WIDTH-1:0]         hit_data_s;
            logic                     hit_vld_s;
            chk_kind_e                kind_s;
            logic [WIDTH-1:0]         data_r;
            logic                     vld_r;
            logic                     err_r;

            assign sel_s = chk_en[r*DEPTH +: DEPTH];

            // AND-OR read of the selected entry; stored data is returned even if invalid.
            always_comb begin
                hit_data_s = {WIDTH{1'b0}};
                hit_vld_s  = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    hit_data_s = hit_data_s | (ent_data_s[i] & {WIDTH{sel_s[i]}});
                    hit_vld_s  = hit_vld_s | (sel_s[i] & ent_vld_s[i]);
                end
            end

            // Zero-extend the select so the shared multi-hot helper sees a fixed width.
            always_comb begin
                sel_ext_s              = {STQ_MAX_DEPTH{1'b0}};
                sel_ext_s[DEPTH-1:0]   = sel_s;
            end

            // Classify the select vector as empty, single hit or multi-hit.
            always_comb begin
                if (stq_multi_hot(sel_ext_s)) begin
                    kind_s = CHK_MULTI;
                end else if (|sel_s) begin
                    kind_s = CHK_HIT;
                end else begin
                    kind_s = CHK_NONE;
                end
            end

            // Output register; a multi-hit suppresses data and valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_r <= {WIDTH{1'b0}};
                    vld_r  <= 1'b0;
                    err_r  <= 1'b0;
                end else begin
                    case (kind_s)
                        CHK_HIT: begin
                            data_r <= hit_data_s;
                            vld_r  <= hit_vld_s;
                            err_r  <= 1'b0;
                        end
                        CHK_MULTI: begin
                            data_r <= {WIDTH{1'b0}};
                            vld_r  <= 1'b0;
                            err_r  <= 1'b1;
                        end
                        default: begin
                            data_r <= {WIDTH{1'b0}};
                            vld_r  <= 1'b0;
                            err_r  <= 1'b0;
                        end
                    endcase
                end
            end

            assign chk_data[r*WIDTH +: WIDTH] = data_r;
            assign chk_vld[r]                 = vld_r;
            assign chk_err[r]                 = err_r;
        end
    endgenerate

endmodule

// File: tb/tb_stq_data_bank.sv
// Randomized self-checking bench for stq_data_bank against a per-byte array model,
// plus directed scenarios for collisions, write/clear races, multi-hit, no-bypass and reset.
module tb_stq_data_bank;

    localparam int W  = 32;
    localparam int D  = 64;
    localparam int NW = 2;
    localparam int NR = 8;
    localparam int NB = W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW*D-1:0]   wrt_en;
    logic [NW*W-1:0]   wrt_data;
    logic [NW*NB-1:0]  wrt_be;
    logic [D-1:0]      clr_en;
    logic [NR*D-1:0]   chk_en;
    logic [NR*W-1:0]   chk_data;
    logic [NR-1:0]     chk_vld;
    logic [NR-1:0]     chk_err;
    logic [D-1:0]      ent_vld;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: data per entry, which bytes have ever been written, valid vector.
    logic [W-1:0]  m_data [D];
    logic [NB-1:0] m_bk   [D];
    logic [D-1:0]  m_vld;

    always #5 clk = ~clk;

    stq_data_bank #(
        .WIDTH (W),
        .DEPTH (D),
        .NWR   (NW),
        .NRD   (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrt_en   (wrt_en),
        .wrt_data (wrt_data),
        .wrt_be   (wrt_be),
        .clr_en   (clr_en),
        .chk_en   (chk_en),
        .chk_data (chk_data),
        .chk_vld  (chk_vld),
        .chk_err  (chk_err),
        .ent_vld  (ent_vld)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        wrt_en   = '0;
        wrt_data = '0;
        wrt_be   = '0;
        clr_en   = '0;
        chk_en   = '0;
    endtask

    // Predict check results from pre-edge model state, advance the model, clock, compare.
    task automatic step();
        logic [W-1:0] e_data [NR];
        bit           e_vld  [NR];
        bit           e_err  [NR];
        bit           e_dk   [NR];
        logic [D-1:0] sel;
        logic [D-1:0] wr_any;
        int           idx;
        for (int r = 0; r < NR; r++) begin
            sel = chk_en[r*D +: D];
            e_data[r] = '0;
            e_vld[r]  = 1'b0;
            e_err[r]  = 1'b0;
            e_dk[r]   = 1'b1;
            if (!rst) begin
                if ($countones(sel) == 1) begin
                    idx = 0;
                    for (int i = 0; i < D; i++) if (sel[i]) idx = i;
                    e_data[r] = m_data[idx];
                    e_dk[r]   = (m_bk[idx] == 4'hF);
                    e_vld[r]  = m_vld[idx];
                end else if ($countones(sel) > 1) begin
                    e_err[r] = 1'b1;
                end
            end
        end
        if (rst) begin
            m_vld = '0;
        end else begin
            wr_any = '0;
            for (int p = 0; p < NW; p++) begin
                for (int i = 0; i < D; i++) begin
                    if (wrt_en[p*D + i]) begin
                        wr_any[i] = 1'b1;
                        for (int b = 0; b < NB; b++) begin
                            if (wrt_be[p*NB + b]) begin
                                m_data[i][b*8 +: 8] = wrt_data[p*W + b*8 +: 8];
                                m_bk[i][b] = 1'b1;
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < D; i++) begin
                if (wr_any[i]) m_vld[i] = 1'b1;
                else if (clr_en[i]) m_vld[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (e_dk[r]) check_val($sformatf("chk_data[%0d]", r), 64'(chk_data[r*W +: W]), 64'(e_data[r]));
            check_val($sformatf("chk_vld[%0d]", r), 64'(chk_vld[r]), 64'(e_vld[r]));
            check_val($sformatf("chk_err[%0d]", r), 64'(chk_err[r]), 64'(e_err[r]));
        end
        check_val("ent_vld", 64'(ent_vld), 64'(m_vld));
    endtask

    task automatic fill_all();
        for (int i = 0; i < D / 2; i++) begin
            idle_inputs();
            wrt_en[2*i]         = 1'b1;
            wrt_en[D + 2*i + 1] = 1'b1;
            wrt_data            = {$urandom, $urandom};
            wrt_be              = 8'hFF;
            step();
        end
    endtask

    task automatic rand_inputs();
        int e1;
        int e2;
        idle_inputs();
        for (int p = 0; p < NW; p++) begin
            case ($urandom_range(0, 3))
                1, 2: wrt_en[p*D + $urandom_range(0, D-1)] = 1'b1;
                3: begin
                    wrt_en[p*D + $urandom_range(0, D-1)] = 1'b1;
                    wrt_en[p*D + $urandom_range(0, D-1)] = 1'b1;
                end
                default: ;
            endcase
            wrt_data[p*W +: W] = $urandom;
            wrt_be[p*NB +: NB] = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 3) == 0) wrt_en[D +: D] = wrt_en[0 +: D];
        for (int i = 0; i < D; i++) clr_en[i] = ($urandom_range(0, 15) == 0);
        for (int r = 0; r < NR; r++) begin
            e1 = $urandom_range(0, D-1);
            case ($urandom_range(0, 9))
                7: ;
                8, 9: begin
                    e2 = (e1 + 1 + $urandom_range(0, D-2)) % D;
                    chk_en[r*D + e1] = 1'b1;
                    chk_en[r*D + e2] = 1'b1;
                end
                default: chk_en[r*D + e1] = 1'b1;
            endcase
        end
        if ($urandom_range(0, 99) == 0) begin
            rst    = 1'b1;
            wrt_en = '0;
            clr_en = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            m_data[i] = '0;
            m_bk[i]   = '0;
        end
        m_vld = '0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_val("reset_ent_vld", 64'(ent_vld), 64'h0);
        check_val("reset_chk_err", 64'(chk_err), 64'h0);
        fill_all();

        // Basic write then check on port 3.
        idle_inputs();
        wrt_en[5] = 1'b1; wrt_data[0 +: W] = 32'hDEADBEEF; wrt_be[0 +: NB] = 4'hF;
        step();
        idle_inputs();
        chk_en[3*D + 5] = 1'b1;
        step();
        check_val("basic_data", 64'(chk_data[3*W +: W]), 64'hDEADBEEF);
        check_val("basic_vld", 64'(chk_vld[3]), 64'h1);
        check_val("basic_err", 64'(chk_err[3]), 64'h0);

        // Same-entry collision: port 1 owns the low bytes it enables.
        idle_inputs();
        wrt_en[7] = 1'b1; wrt_en[D + 7] = 1'b1;
        wrt_data = {32'h22222222, 32'h11111111}; wrt_be = {4'h3, 4'hF};
        step();
        idle_inputs();
        chk_en[7] = 1'b1;
        step();
        check_val("collision_data", 64'(chk_data[0 +: W]), 64'h11112222);

        // Write beats clear, then a lone clear invalidates.
        idle_inputs();
        wrt_en[9] = 1'b1; wrt_data[0 +: W] = 32'h0BADF00D; wrt_be[0 +: NB] = 4'h0; clr_en[9] = 1'b1;
        step();
        check_val("wrclr_vld", 64'(ent_vld[9]), 64'h1);
        idle_inputs();
        clr_en[9] = 1'b1;
        step();
        check_val("clr_vld", 64'(ent_vld[9]), 64'h0);
        idle_inputs();
        chk_en[9] = 1'b1;
        step();
        check_val("clr_chk_vld", 64'(chk_vld[0]), 64'h0);

        // Multi-hit on port 0.
        idle_inputs();
        chk_en[2] = 1'b1; chk_en[40] = 1'b1;
        step();
        check_val("multi_err", 64'(chk_err[0]), 64'h1);
        check_val("multi_data", 64'(chk_data[0 +: W]), 64'h0);
        check_val("multi_vld", 64'(chk_vld[0]), 64'h0);

        // No same-cycle bypass.
        idle_inputs();
        wrt_en[3] = 1'b1; wrt_data[0 +: W] = 32'h01020304; wrt_be[0 +: NB] = 4'hF;
        step();
        idle_inputs();
        wrt_en[3] = 1'b1; wrt_data[0 +: W] = 32'hA5A5A5A5; wrt_be[0 +: NB] = 4'hF;
        chk_en[3] = 1'b1;
        step();
        check_val("nobypass_old", 64'(chk_data[0 +: W]), 64'h01020304);
        idle_inputs();
        chk_en[3] = 1'b1;
        step();
        check_val("nobypass_new", 64'(chk_data[0 +: W]), 64'hA5A5A5A5);

        // Reset with valid entries and checks in flight.
        idle_inputs();
        chk_en[D + 5] = 1'b1;
        step();
        idle_inputs();
        rst = 1'b1; chk_en[2*D + 7] = 1'b1; chk_en[5] = 1'b1;
        step();
        check_val("rst_ent_vld", 64'(ent_vld), 64'h0);
        check_val("rst_chk_data", 64'(|chk_data), 64'h0);
        check_val("rst_chk_vld", 64'(chk_vld), 64'h0);
        check_val("rst_chk_err", 64'(chk_err), 64'h0);

        fill_all();
        for (int c = 0; c < 500; c++) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
